// File: rtl/mux_pkt_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkt_arbiter_pkg
// Shared constants for the router output-stage arbiter and its mux:
//   - flit-type codes carried in the top bits of each flit
//   - arbiter FSM state codes (single-bit, legacy-compatible constants)
//   - helper that checks a flit-type field against a code
// ---------------------------------------------------------------------------
package mux_pkt_arbiter_pkg;

    localparam int TYPEW_DEF = 2;

    typedef enum logic [TYPEW_DEF-1:0] {
        TYPE_NONE = 2'd0,
        TYPE_HEAD = 2'd1,
        TYPE_DATA = 2'd2,
        TYPE_TAIL = 2'd3
    } flit_type_e;

    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_LOCK = 1'b1;

    // Compare a flit-type field against one code.
    function automatic logic type_is(input logic [TYPEW_DEF-1:0] ftype,
                                     input flit_type_e          code);
        return (ftype == code);
    endfunction

endpackage

// File: rtl/mux_pkt_arbiter_rr_pick2.sv
// ---------------------------------------------------------------------------
// arb_rr_pick2
// Combinational two-requester round-robin pick. When both request, the
// pointer decides; otherwise the single requester wins.
// Ports:
//   req[1:0]  in   request per port
//   ptr       in   preferred port when both request
//   gnt_idx   out  index of the winning port (meaningful only when any=1)
//   any       out  at least one request present
// ---------------------------------------------------------------------------
module arb_rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       gnt_idx,
    output logic       any
);

    assign any     = |req;
    assign gnt_idx = (req == 2'b11) ? ptr : req[1];

endmodule

// File: rtl/mux_pkt_arbiter.sv
// ---------------------------------------------------------------------------
// mux_pkt_arbiter
// Wormhole packet arbiter driving the select of the 2:1 router output mux.
// A HEAD flit wins the output; the mux stays on that port until its TAIL
// flit is accepted downstream. Ties between simultaneous HEADs are broken
// round-robin.
//
// Optional feature: define ARB_TIMEOUT_EN to release a lock that has seen
// TIMEOUT consecutive cycles without a grant (otimeout pulses once).
//
// Ports:
//   clk        in   router clock
//   rst_       in   synchronous active-low reset
//   ivalid_0/1 in   per-port flit valid
//   itype_0/1  in   per-port flit type (TYPEW bits)
//   ordy       in   downstream accepts a flit this cycle
//   sel        out  registered mux select (0 = port 0, 1 = port 1)
//   ogrant_0/1 out  flit transferred from that port this cycle
//   obusy      out  lock held
//   otimeout   out  one-cycle pulse after a forced release
// ---------------------------------------------------------------------------
module mux_pkt_arbiter
    import mux_pkt_arbiter_pkg::*;
#(
    parameter int TYPEW   = 2,
    parameter int TIMEOUT = 16,
    parameter int CNTW    = 8
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             ivalid_0,
    input  logic [TYPEW-1:0] itype_0,
    input  logic             ivalid_1,
    input  logic [TYPEW-1:0] itype_1,
    input  logic             ordy,
    output logic             sel,
    output logic             ogrant_0,
    output logic             ogrant_1,
    output logic             obusy,
    output logic             otimeout
);

    if (TIMEOUT < 2 || TIMEOUT > 255 || (CNTW < 31 && (1 << CNTW) <= TIMEOUT)) begin : g_bad_cfg
        $error("mux_pkt_arbiter: TIMEOUT must be 2..255 and fit in CNTW bits");
    end

    logic [0:0] state_q, state_d;
    logic       sel_q,   sel_d;
    logic       rr_q,    rr_d;
    logic       tout_q,  tout_d;

    logic [1:0] head_req;
    logic       pick_idx;
    logic       pick_any;
    logic       locked;
    logic       gnt_0;
    logic       gnt_1;
    logic       granted;
    logic [TYPEW-1:0] gnt_type;
    logic       tail_acc;

    assign head_req[0] = ivalid_0 && (itype_0 == TYPEW'(TYPE_HEAD));
    assign head_req[1] = ivalid_1 && (itype_1 == TYPEW'(TYPE_HEAD));

    arb_rr_pick2 u_pick (
        .req     (head_req),
        .ptr     (rr_q),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // Grants come only from registered state, and are suppressed while
    // reset is asserted so an abandoned packet never pops a flit.
    assign locked   = (state_q == ARB_LOCK);
    assign gnt_0    = rst_ && locked && !sel_q && ivalid_0 && ordy;
    assign gnt_1    = rst_ && locked &&  sel_q && ivalid_1 && ordy;
    assign granted  = gnt_0 || gnt_1;
    assign gnt_type = sel_q ? itype_1 : itype_0;
    assign tail_acc = granted && (gnt_type == TYPEW'(TYPE_TAIL));

`ifdef ARB_TIMEOUT_EN
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            stall_limit;

    assign stall_limit = locked && !granted && (cnt_q == CNTW'(TIMEOUT - 1));
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        tout_d  = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    sel_d   = pick_idx;
                    state_d = ARB_LOCK;
                end
            end
            ARB_LOCK: begin
                if (tail_acc) begin
                    // sel keeps pointing at the finished port; only the
                    // round-robin pointer moves on.
                    state_d = ARB_IDLE;
                    rr_d    = ~sel_q;
                end
`ifdef ARB_TIMEOUT_EN
                else if (stall_limit) begin
                    state_d = ARB_IDLE;
                    rr_d    = ~sel_q;
                    tout_d  = 1'b1;
                end else if (!granted) begin
                    cnt_d   = cnt_q + CNTW'(1);
                end
`endif
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q <= ARB_IDLE;
            sel_q   <= 1'b0;
            rr_q    <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            tout_q  <= tout_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign otimeout = tout_q;
`else
    // Without the timeout feature the pulse register never sets.
    assign otimeout = tout_q;
`endif

    assign sel      = sel_q;
    assign ogrant_0 = gnt_0;
    assign ogrant_1 = gnt_1;
    assign obusy    = locked;

endmodule

// File: tb/tb_mux_pkt_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux_pkt_arbiter
// Directed scenarios plus randomized packet traffic, checked every cycle
// against a packet-level reference model (lock owner, round-robin turn,
// idle-cycle count).
// ---------------------------------------------------------------------------
module tb_mux_pkt_arbiter;

    localparam int TYPEW   = 2;
    localparam int TIMEOUT = 8;
    localparam int CNTW    = 8;

    logic             clk = 1'b0;
    logic             rst_;
    logic             ivalid_0, ivalid_1;
    logic [TYPEW-1:0] itype_0, itype_1;
    logic             ordy;
    logic             sel, ogrant_0, ogrant_1, obusy, otimeout;

    always #5 clk = ~clk;

    mux_pkt_arbiter #(.TYPEW(TYPEW), .TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
        .clk      (clk),
        .rst_     (rst_),
        .ivalid_0 (ivalid_0),
        .itype_0  (itype_0),
        .ivalid_1 (ivalid_1),
        .itype_1  (itype_1),
        .ordy     (ordy),
        .sel      (sel),
        .ogrant_0 (ogrant_0),
        .ogrant_1 (ogrant_1),
        .obusy    (obusy),
        .otimeout (otimeout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: who owns the output (-1 = nobody), whose turn it is
    // on a tie, and how long the owner has gone without a transfer.
    int m_owner = -1;
    int m_sel   = 0;
    int m_rr    = 0;
    int m_idle  = 0;
    int m_tout  = 0;

    // Upstream packet sources.
    int s_len[2];
    int s_pos[2];
    bit s_act[2];
    int vprob = 100;

    // Observations from the most recent step.
    logic obs_sel, obs_busy, obs_tout;
    logic obs_g[2];
    int   g_cnt[2];
    bit   prev_busy = 1'b0;
    int   winners[$];

    function automatic int flit_type(input int p);
        if (s_pos[p] == 0)            return 1;
        if (s_pos[p] == s_len[p] - 1) return 3;
        return 2;
    endfunction

    task automatic new_pkt(input int p, input int len);
        s_len[p] = len;
        s_pos[p] = 0;
        s_act[p] = 1'b1;
    endtask

    task automatic drive();
        ivalid_0 = s_act[0] && ($urandom_range(0, 99) < vprob);
        itype_0  = s_act[0] ? TYPEW'(flit_type(0)) : '0;
        ivalid_1 = s_act[1] && ($urandom_range(0, 99) < vprob);
        itype_1  = s_act[1] ? TYPEW'(flit_type(1)) : '0;
    endtask

    // One clock cycle: check outputs against the model at the falling
    // edge, then advance model and sources at the rising edge.
    task automatic step();
        int  e_g[2];
        int  v[2];
        int  t[2];
        int  tout_n;
        int  h0, h1;
        @(negedge clk);
        v[0] = ivalid_0; v[1] = ivalid_1;
        t[0] = itype_0;  t[1] = itype_1;
        for (int p = 0; p < 2; p++)
            e_g[p] = (rst_ && m_owner == p && v[p] != 0 && ordy) ? 1 : 0;
        check("sel",      sel,      m_sel);
        check("ogrant_0", ogrant_0, e_g[0]);
        check("ogrant_1", ogrant_1, e_g[1]);
        check("obusy",    obusy,    (m_owner >= 0) ? 1 : 0);
        check("otimeout", otimeout, m_tout);
        obs_sel  = sel;
        obs_busy = obusy;
        obs_tout = otimeout;
        obs_g[0] = ogrant_0;
        obs_g[1] = ogrant_1;
        g_cnt[0] += int'(ogrant_0);
        g_cnt[1] += int'(ogrant_1);
        if (obusy && !prev_busy) winners.push_back(int'(sel));
        prev_busy = obusy;

        @(posedge clk);
        tout_n = 0;
        if (!rst_) begin
            m_owner = -1;
            m_sel   = 0;
            m_rr    = 0;
            m_idle  = 0;
        end else if (m_owner < 0) begin
            h0 = (v[0] != 0 && t[0] == 1) ? 1 : 0;
            h1 = (v[1] != 0 && t[1] == 1) ? 1 : 0;
            if (h0 + h1 > 0) begin
                m_sel   = (h0 + h1 == 2) ? m_rr : h1;
                m_owner = m_sel;
                m_idle  = 0;
            end
        end else if (e_g[m_owner] != 0) begin
            m_idle = 0;
            if (t[m_owner] == 3) begin
                m_rr    = 1 - m_owner;
                m_owner = -1;
            end
        end else begin
`ifdef ARB_TIMEOUT_EN
            m_idle++;
            if (m_idle == TIMEOUT) begin
                m_rr    = 1 - m_owner;
                m_owner = -1;
                m_idle  = 0;
                tout_n  = 1;
            end
`endif
        end
        m_tout = tout_n;

        for (int p = 0; p < 2; p++) begin
            if (e_g[p] != 0) begin
                if (s_pos[p] == s_len[p] - 1) s_act[p] = 1'b0;
                else                          s_pos[p]++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_     = 1'b0;
        s_act[0] = 1'b0;
        s_act[1] = 1'b0;
        drive();
        step();
        rst_ = 1'b1;
    endtask

    initial begin
        int done[2];
        rst_     = 1'b0;
        ordy     = 1'b1;
        ivalid_0 = 1'b0; ivalid_1 = 1'b0;
        itype_0  = '0;   itype_1  = '0;
        s_act[0] = 1'b0; s_act[1] = 1'b0;
        g_cnt[0] = 0;    g_cnt[1] = 0;
        #1;

        // Reset held two cycles with HEADs on both ports, then strict
        // alternation of winners for back-to-back packets.
        new_pkt(0, 3);
        new_pkt(1, 4);
        done[0] = 1; done[1] = 1;
        drive(); step();
        check("rst_sel", obs_sel, 0);
        check("rst_g0",  obs_g[0], 0);
        drive(); step();
        check("rst_g1",  obs_g[1], 0);
        check("rst_busy", obs_busy, 0);
        rst_ = 1'b1;
        drive(); step();
        check("post_rst_busy", obs_busy, 0);
        check("post_rst_g0",   obs_g[0], 0);
        for (int i = 0; i < 80 && (done[0] < 3 || done[1] < 3 || s_act[0] || s_act[1]); i++) begin
            drive(); step();
            for (int p = 0; p < 2; p++)
                if (!s_act[p] && done[p] < 3) begin new_pkt(p, 3 + p); done[p]++; end
        end
        check("alt_count", winners.size(), 6);
        for (int i = 0; i < winners.size(); i++)
            check("alt_order", winners[i], i % 2);

        // Port 1: HEAD + 20 DATA + TAIL with ordy high.
        do_reset();
        new_pkt(1, 22);
        drive(); step();
        g_cnt[1] = 0;
        drive(); step();
        check("p1_sel",  obs_sel, 1);
        check("p1_busy", obs_busy, 1);
        for (int i = 0; i < 60 && s_act[1]; i++) begin drive(); step(); end
        check("p1_done",   s_act[1], 0);
        check("p1_grants", g_cnt[1], 22);
        drive(); step();
        check("p1_release", obs_busy, 0);

        // Port 0 locked, downstream stalls for 3 cycles mid-packet.
        do_reset();
        new_pkt(0, 10);
        drive(); step();
        for (int i = 0; i < 20 && s_pos[0] < 4; i++) begin drive(); step(); end
        ordy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(); step();
            check("stall_g0",   obs_g[0], 0);
            check("stall_sel",  obs_sel, 0);
            check("stall_busy", obs_busy, 1);
        end
        ordy = 1'b1;
        drive(); step();
        check("stall_resume", obs_g[0], 1);
        for (int i = 0; i < 20 && s_act[0]; i++) begin drive(); step(); end

        // Locked port goes silent for TIMEOUT cycles.
        do_reset();
        new_pkt(0, 6);
        drive(); step();
        drive(); step();
        for (int i = 0; i < TIMEOUT; i++) begin
            drive(); ivalid_0 = 1'b0; step();
        end
        drive(); ivalid_0 = 1'b0; step();
`ifdef ARB_TIMEOUT_EN
        check("to_pulse", obs_tout, 1);
        check("to_busy",  obs_busy, 0);
        new_pkt(0, 3);
        new_pkt(1, 3);
        drive(); step();
        drive(); step();
        check("to_next_winner", obs_sel, 1);
`else
        check("to_pulse", obs_tout, 0);
        check("to_busy",  obs_busy, 1);
`endif

        // Reset after 5 DATA flits of a port 1 packet.
        do_reset();
        new_pkt(1, 22);
        drive(); step();
        for (int i = 0; i < 20 && s_pos[1] < 6; i++) begin drive(); step(); end
        rst_ = 1'b0;
        drive(); step();
        check("mid_rst_g1", obs_g[1], 0);
        rst_ = 1'b1;
        g_cnt[1] = 0;
        for (int i = 0; i < 4; i++) begin
            drive(); step();
            check("mid_rst_busy", obs_busy, 0);
            check("mid_rst_sel",  obs_sel, 0);
        end
        check("mid_rst_nogrant", g_cnt[1], 0);
        new_pkt(0, 3);
        new_pkt(1, 3);
        drive(); step();
        drive(); step();
        check("mid_rst_rr", obs_sel, 0);

        // Randomized traffic with stalls, gaps and occasional resets.
        do_reset();
        vprob = 75;
        for (int i = 0; i < 3000; i++) begin
            ordy = ($urandom_range(0, 99) < 80);
            rst_ = ($urandom_range(0, 199) != 0);
            if (!rst_) begin s_act[0] = 1'b0; s_act[1] = 1'b0; end
            for (int p = 0; p < 2; p++)
                if (!s_act[p] && rst_ && $urandom_range(0, 3) == 0)
                    new_pkt(p, $urandom_range(2, 8));
            drive();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
